led_cmd_sequencer: RTL and testbench
====================================

# led_cmd_sequencer

Command front-end for the LED controller array. It samples the host's asynchronous serial link (SCLK, DATA, LATCH) in the system clock domain and assembles 8-bit command frames. Each frame is decoded into a 3-bit instruction and a 5-bit LED address and written into a per-LED state register file. It also generates the two blink patterns consumed by every per-LED controller, replacing the unclocked latch logic in the top level.

## Interface
- NUM_LEDS, 23, number of LED state slots (≤ 31)
- CMD_W, 8, frame length in bits; instruction = [7:5], address = [4:0]
- PRESCALE_W, 20, width of free-running pattern counter (≥ 3)

- CLK  in  1  system clock
- RESET  in  1  reset; one clock; asynchronous, active-high
- SCLK  in  1  host serial clock, asynchronous to CLK
- DATA  in  1  host serial data, MSB first, sampled on SCLK rising edge
- LATCH  in  1  host frame commit, rising edge commits
- led_state  out  3*NUM_LEDS  slot i at [3i+2:3i]
- pattern1  out  1  slow blink
- pattern2  out  1  fast blink
- cmd_strobe  out  1  one-cycle pulse, valid command applied
- cmd_error  out  1  one-cycle pulse, frame rejected

## Operation
- SCLK, LATCH, DATA each pass a 2-flop synchronizer. SCLK and LATCH get rising-edge detect on the synchronized value.
- FSM states:
  - IDLE: bit count 0.
  - SHIFT: bit count 1..CMD_W.
  - COMMIT: one cycle.
- SCLK rise with synchronized LATCH low: shift synchronized DATA into the LSB of the shift register. Bit count increments and saturates at CMD_W; IDLE→SHIFT.
- More than CMD_W bits: keep shifting; the last CMD_W bits are kept.
- LATCH rise from IDLE or SHIFT → COMMIT.
- COMMIT with bit count == CMD_W:
  - addr < NUM_LEDS: slot[addr] ← instr; cmd_strobe.
  - addr == 31: all slots ← instr (broadcast); cmd_strobe.
  - otherwise: cmd_error, no write.
- COMMIT with bit count < CMD_W (including 0): cmd_error, no write.
- COMMIT → IDLE; bit count and shift register cleared.
- SCLK rise in the same cycle as a LATCH rise, or while LATCH is high: ignored.
- Pattern counter runs freely from reset. pattern1 = cnt[PRESCALE_W-1], pattern2 = cnt[PRESCALE_W-3] (4× pattern1 rate).
- Instruction values are opaque to this block and stored verbatim.

## Timing
- Reset values: led_state all 0, pattern1 = pattern2 = 0, cmd_strobe = cmd_error = 0. FSM in IDLE; counters, shift register and synchronizers all 0.
- Input edge to edge-detect pulse: 2 CLK cycles of synchronizer, then pulse in cycle 3.
- LATCH rise to result:
  - led_state update and cmd_strobe/cmd_error pulse are registered and visible in cycle 4.
  - Exactly one of cmd_strobe / cmd_error pulses per commit.
- Host rules:
  - SCLK high and low each ≥ 3 CLK periods.
  - DATA stable ≥ 3 CLK before and after SCLK rise.
  - LATCH high ≥ 3 CLK.
  - ≥ 4 CLK from LATCH fall to the next SCLK rise.
- Host holds SCLK and LATCH low through reset. A high input at release is seen as a rising edge; a LATCH edge there yields cmd_error with no write.
- RESET asserted mid-frame: partial frame discarded, all slots to 0 immediately.
- Pattern counter wraps at 2^PRESCALE_W with no gap.
- pattern1 period = 2^PRESCALE_W cycles at 50 % duty.

## Structure
- Package led_ctrl_pkg:
  - CMD_W, ADDR_W = 5, INSTR_W = 3, ADDR_BROADCAST = 5'd31.
  - Instruction encodings shared with the per-LED controller: OFF = 0, ON = 1, BLINK_SLOW = 2, BLINK_FAST = 3.
  - FSM state enum.
- Sub-module sync_edge: 2-flop synchronizer plus registered rising-edge pulse. Instantiated for SCLK and LATCH; DATA uses the synchronizer output only.
- Slot storage is a flat register vector with per-slot write enable; no memory macro.

## Test plan
- Reset, then shift 8'h21 and pulse LATCH → led_state[5:3] = 3'b001, all other slots 0; cmd_strobe high one cycle, 4 CLK after LATCH rise.
- Shift 8'h5F (instr 2, addr 31) and latch → all 23 slots = 3'b010; single cmd_strobe.
- Shift 8'h39 (addr 25 ≥ NUM_LEDS) and latch → cmd_error pulse, led_state unchanged. Then shift 5 bits and latch → cmd_error, unchanged.
- Shift 10 bits ending in 8'h67 and latch → slot 7 = 3'b011. Then assert RESET after 4 bits of 8'hE2 → led_state all 0; a following clean 8'h22 frame writes slot 2 = 3'b001.
- PRESCALE_W = 4 → pattern1 toggles every 8 CLK and pattern2 every 2 CLK, both starting at 0 after reset. SCLK edge coincident with LATCH rise is not shifted.

Source files
------------

// File: rtl/led_cmd_sequencer_pkg.sv
// Shared constants, instruction encodings and sequencer FSM states for the LED
// command front-end and the per-LED controllers.
package led_ctrl_pkg;

  localparam int CMD_W   = 8;
  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 3;
  localparam int CNT_W   = $clog2(CMD_W + 1);

  localparam logic [ADDR_W-1:0] ADDR_BROADCAST = 5'd31;

  typedef enum logic [INSTR_W-1:0] {
    INSTR_OFF        = 3'd0,
    INSTR_ON         = 3'd1,
    INSTR_BLINK_SLOW = 3'd2,
    INSTR_BLINK_FAST = 3'd3
  } instr_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/led_cmd_sequencer_if.sv
// Host serial link plus LED state/pattern outputs of the command sequencer.
interface led_cmd_sequencer_if #(
  parameter int NUM_LEDS = 23
);
  logic                  SCLK;
  logic                  DATA;
  logic                  LATCH;
  logic [3*NUM_LEDS-1:0] led_state;
  logic                  pattern1;
  logic                  pattern2;
  logic                  cmd_strobe;
  logic                  cmd_error;

  modport master (
    output SCLK, DATA, LATCH,
    input  led_state, pattern1, pattern2, cmd_strobe, cmd_error
  );

  modport slave (
    input  SCLK, DATA, LATCH,
    output led_state, pattern1, pattern2, cmd_strobe, cmd_error
  );
endinterface

// File: rtl/led_cmd_sequencer_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge pulse; the pulse appears
// in the third clock after the asynchronous input rises.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);
  logic meta_q, sync_q, prev_q, rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;
endmodule

// File: rtl/led_cmd_sequencer.sv
// Assembles host serial frames into per-LED instruction slots and generates
// the shared slow/fast blink patterns.
module led_cmd_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS   = 23,
  parameter int PRESCALE_W = 20
) (
  input logic CLK,
  input logic RESET,
  led_cmd_sequencer_if.slave bus
);
  localparam logic [ADDR_W-1:0] NUM_LEDS_A = ADDR_W'(NUM_LEDS);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(CMD_W);

  logic sclk_rise, latch_sync, latch_rise;
  logic data_meta_q, data_sync_q;

  state_e                state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [CMD_W-1:0]      shreg_q;
  logic [3*NUM_LEDS-1:0] slots_q;
  logic                  strobe_q, error_q;
  logic [PRESCALE_W-1:0] cnt_q;

  logic                latch_go, shift_go, frame_full, addr_hit, bcast, accept;
  logic [ADDR_W-1:0]   addr;
  logic [INSTR_W-1:0]  instr;
  logic [NUM_LEDS-1:0] slot_we;

  sync_edge u_sclk (
    .clk     (CLK),
    .rst     (RESET),
    .async_i (bus.SCLK),
    .sync_o  (),
    .rise_o  (sclk_rise)
  );

  sync_edge u_latch (
    .clk     (CLK),
    .rst     (RESET),
    .async_i (bus.LATCH),
    .sync_o  (latch_sync),
    .rise_o  (latch_rise)
  );

  // DATA is only ever consumed on an SCLK pulse, so a level synchronizer suffices.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
    end else begin
      data_meta_q <= bus.DATA;
      data_sync_q <= data_meta_q;
    end
  end

  always_comb begin
    addr       = shreg_q[ADDR_W-1:0];
    instr      = shreg_q[CMD_W-1 -: INSTR_W];
    frame_full = (bit_cnt_q == FULL_CNT);
    addr_hit   = (addr < NUM_LEDS_A);
    bcast      = (addr == ADDR_BROADCAST);
    latch_go   = latch_rise && (state_q != ST_COMMIT);
    // A held-high LATCH also masks an SCLK edge arriving alongside its rise.
    shift_go   = sclk_rise && !latch_sync && (state_q != ST_COMMIT);
    accept     = latch_go && frame_full && (addr_hit || bcast);
    for (int i = 0; i < NUM_LEDS; i++) begin
      slot_we[i] = accept && (bcast || (addr == ADDR_W'(i)));
    end
  end

  // The commit decision is taken on the edge that enters COMMIT, so the write
  // and the strobe/error pulse land together one cycle after the LATCH pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      slots_q   <= '0;
      strobe_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      error_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_SHIFT: begin
          if (latch_go) begin
            state_q  <= ST_COMMIT;
            strobe_q <= accept;
            error_q  <= !accept;
            for (int i = 0; i < NUM_LEDS; i++) begin
              if (slot_we[i]) slots_q[3*i +: 3] <= instr;
            end
          end else if (shift_go) begin
            state_q <= ST_SHIFT;
            shreg_q <= {shreg_q[CMD_W-2:0], data_sync_q};
            if (!frame_full) bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
          shreg_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_q + 1'b1;
  end

  assign bus.led_state  = slots_q;
  assign bus.pattern1   = cnt_q[PRESCALE_W-1];
  assign bus.pattern2   = cnt_q[PRESCALE_W-3];
  assign bus.cmd_strobe = strobe_q;
  assign bus.cmd_error  = error_q;
endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Scoreboarded bench: host driver pushes expected commit results, monitor pops on each pulse.
module tb_led_cmd_sequencer;
  localparam int NL = 23;
  localparam int PW = 4;
  localparam int SW = 3 * NL;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  led_cmd_sequencer_if #(.NUM_LEDS(NL)) bus ();

  led_cmd_sequencer #(.NUM_LEDS(NL), .PRESCALE_W(PW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit            err;
    logic [SW-1:0] st;
    int            cyc;
  } exp_t;

  exp_t          expq[$];
  bit            frame_bits[$];
  logic [2:0]    model[NL];
  logic [SW-1:0] cur_exp = '0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            pc = 0;

  task automatic check(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [SW-1:0] pack_model();
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[3*i +: 3] = model[i];
    return r;
  endfunction

  // Monitor: free-running pattern reference plus scoreboard pops.
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #2;
      if (RESET) pc = 0;
      else pc = (pc + 1) % (1 << PW);
      check("pattern1", SW'(bus.pattern1), SW'((pc >> (PW - 1)) & 1));
      check("pattern2", SW'(bus.pattern2), SW'((pc >> (PW - 3)) & 1));
      if (bus.cmd_strobe || bus.cmd_error) begin
        if (expq.size() == 0) begin
          check("unexpected_pulse", SW'({bus.cmd_strobe, bus.cmd_error}), '0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("pulse_kind", SW'({bus.cmd_strobe, bus.cmd_error}), e.err ? SW'(2'b01) : SW'(2'b10));
          check("pulse_cycle", SW'(cyc), SW'(e.cyc));
          check("led_state_commit", bus.led_state, e.st);
          cur_exp = e.st;
        end
      end else begin
        check("led_state_hold", bus.led_state, cur_exp);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input bit b);
    @(negedge CLK);
    bus.DATA = b;
    wait_clk(3);
    bus.SCLK = 1'b1;
    frame_bits.push_back(b);
    wait_clk(3);
    bus.SCLK = 1'b0;
    wait_clk(3);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  // Raises LATCH and records the expected outcome; optionally raises SCLK on the same edge.
  task automatic latch(input bit with_sclk);
    exp_t        e;
    int          n;
    logic [7:0]  v;
    int          a;
    @(negedge CLK);
    if (with_sclk) begin
      bus.DATA = 1'b1;
      wait_clk(3);
      bus.SCLK = 1'b1;
    end
    bus.LATCH = 1'b1;
    n = frame_bits.size();
    e.err = 1'b1;
    if (n >= 8) begin
      for (int i = 0; i < 8; i++) v[7 - i] = frame_bits[n - 8 + i];
      a = int'(v[4:0]);
      if (a < NL) begin
        model[a] = v[7:5];
        e.err = 1'b0;
      end else if (a == 31) begin
        for (int i = 0; i < NL; i++) model[i] = v[7:5];
        e.err = 1'b0;
      end
    end
    e.st  = pack_model();
    e.cyc = cyc + 4;
    expq.push_back(e);
    frame_bits.delete();
    wait_clk(3);
    bus.LATCH = 1'b0;
    bus.SCLK  = 1'b0;
    wait_clk(4);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 30) begin
      @(negedge CLK);
      t++;
    end
    if (expq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d commit results still pending, required 0", expq.size());
      expq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < NL; i++) model[i] = 3'd0;
    frame_bits.delete();
    cur_exp = '0;
    wait_clk(2);
    RESET = 1'b0;
  endtask

  initial begin
    int         len, sel, addr, ins;
    logic [7:0] v;
    bus.SCLK  = 1'b0;
    bus.DATA  = 1'b0;
    bus.LATCH = 1'b0;
    for (int i = 0; i < NL; i++) model[i] = 3'd0;
    wait_clk(3);
    RESET = 1'b0;
    wait_clk(2);

    send_bits(16'h21, 8);  latch(1'b0); drain();
    send_bits(16'h5F, 8);  latch(1'b0); drain();
    send_bits(16'h39, 8);  latch(1'b0); drain();
    send_bits(16'h15, 5);  latch(1'b0); drain();
    latch(1'b0); drain();
    send_bits(16'h267, 10); latch(1'b0); drain();

    send_bits(16'hE, 4);
    do_reset();
    wait_clk(4);
    send_bits(16'h22, 8);  latch(1'b0); drain();

    // A bit offered on the LATCH rise edge would turn 0x21 into 0x43 if shifted.
    send_bits(16'h21, 8);  latch(1'b1); drain();

    for (int f = 0; f < 30; f++) begin
      len  = $urandom_range(0, 11);
      sel  = $urandom_range(0, 3);
      addr = (sel < 2) ? $urandom_range(0, NL - 1) : (sel == 2) ? 31 : $urandom_range(NL, 30);
      ins  = $urandom_range(0, 7);
      v    = {3'(ins), 5'(addr)};
      if (len >= 8) begin
        for (int i = 0; i < len - 8; i++) send_bit(1'($urandom_range(0, 1)));
        send_bits({8'h00, v}, 8);
      end else begin
        for (int i = 0; i < len; i++) send_bit(1'($urandom_range(0, 1)));
      end
      latch(1'b0);
      drain();
    end

    wait_clk(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
